fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 99 +++++++++
 tb/tb_fetch_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencer: walks ProgCtr through the instruction
// ROM, redirects on taken branches through a small target LUT, and owns the
// IDLE/RUN/DONE run handshake for the core.
module fetch_sequencer #(
  parameter int PC_W     = 10,
  parameter int LUT_AW   = 3,
  parameter int PROG_LEN = 1024
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Branch,
  input  logic              Taken,
  input  logic [LUT_AW-1:0] TargetIdx,
  input  logic              Halt,
  input  logic              LutWe,
  input  logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   LutData,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Fetch,
  output logic              Done
);

  localparam int LUT_N = 1 << LUT_AW;
  // Compare in 32 bits so PROG_LEN == 2**PC_W still works without truncation.
  localparam logic [31:0] LEN  = 32'(PROG_LEN);
  localparam logic [31:0] LAST = 32'(PROG_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [PC_W-1:0]     pc_nxt;
  logic [PC_W-1:0]     lut [LUT_N];
  logic [PC_W-1:0]     target;

  // Combinational LUT read; a write in this cycle lands after the edge, so a
  // branch reading the same entry sees the old value.
  assign target = lut[TargetIdx];

  // State and program counter register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      ProgCtr <= '0;
    end else begin
      state   <= state_nxt;
      ProgCtr <= pc_nxt;
    end
  end

  // Branch-target LUT storage, writable in any state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else if (LutWe) begin
      lut[LutAddr] <= LutData;
    end
  end

  // Next-state and next-PC selection: halt, then taken branch, then runoff,
  // then sequential increment.
  always_comb begin
    state_nxt = state;
    pc_nxt    = ProgCtr;
    unique case (state)
      IDLE: begin
        pc_nxt = '0;
        if (Start) state_nxt = RUN;
      end
      RUN: begin
        if (Halt) begin
          state_nxt = DONE;
        end else if (Branch && Taken) begin
          if (32'(target) < LEN) pc_nxt = target;
          else state_nxt = DONE;
        end else if (32'(ProgCtr) == LAST) begin
          state_nxt = DONE;
        end else begin
          pc_nxt = ProgCtr + PC_W'(1);
        end
      end
      DONE: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = '0;
      end
    endcase
  end

  // Moore outputs from state only.
  assign Fetch = (state == RUN);
  assign Done  = (state == DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer with a behavioural run model and a few
// directed sequences covering branch, halt, LUT hazard, out-of-range target,
// runoff and asynchronous reset.
module tb_fetch_sequencer;
  localparam int PC_W = 10, LUT_AW = 3, PLEN = 8;

  logic              Clk = 1'b0, Reset = 1'b1, Start = 1'b0;
  logic              Branch = 1'b0, Taken = 1'b0, Halt = 1'b0, LutWe = 1'b0;
  logic [LUT_AW-1:0] TargetIdx = '0, LutAddr = '0;
  logic [PC_W-1:0]   LutData = '0;
  logic [PC_W-1:0]   ProgCtr;
  logic              Fetch, Done;

  fetch_sequencer #(.PC_W(PC_W), .LUT_AW(LUT_AW), .PROG_LEN(PLEN)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch), .Taken(Taken),
    .TargetIdx(TargetIdx), .Halt(Halt), .LutWe(LutWe), .LutAddr(LutAddr),
    .LutData(LutData), .ProgCtr(ProgCtr), .Fetch(Fetch), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int checks = 0, failures = 0;

  // Reference model: is the core running / finished, where is it, LUT contents.
  bit running, finished;
  int m_pc;
  int m_lut [8];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    running = 0; finished = 0; m_pc = 0;
    foreach (m_lut[i]) m_lut[i] = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".pc"},    int'(ProgCtr), m_pc);
    chk({tag, ".fetch"}, int'(Fetch),   int'(running));
    chk({tag, ".done"},  int'(Done),    int'(finished));
  endtask

  // Called at a falling edge: apply inputs, advance the model, then check
  // the DUT at the next falling edge.
  task automatic step(input bit st, input bit br, input bit tk, input int ti,
                      input bit hl, input bit we, input int wa, input int wd,
                      input string tag);
    Start = st; Branch = br; Taken = tk; TargetIdx = LUT_AW'(ti); Halt = hl;
    LutWe = we; LutAddr = LUT_AW'(wa); LutData = PC_W'(wd);
    if (running) begin
      if (hl) begin
        running = 0; finished = 1;
      end else if (br && tk) begin
        if (m_lut[ti] < PLEN) m_pc = m_lut[ti];
        else begin running = 0; finished = 1; end
      end else if (m_pc == PLEN - 1) begin
        running = 0; finished = 1;
      end else begin
        m_pc = m_pc + 1;
      end
    end else if (st) begin
      running = 1; finished = 0; m_pc = 0;
    end
    if (we) m_lut[wa] = wd;
    @(negedge Clk);
    check_outputs(tag);
  endtask

  task automatic idle_step(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge,
  // and Start held during reset must be ignored.
  task automatic async_reset(input string tag);
    @(posedge Clk);
    #2 Reset = 1'b1; Start = 1'b1;
    model_reset();
    #1 check_outputs({tag, ".imm"});
    @(negedge Clk);
    @(negedge Clk);
    check_outputs({tag, ".held"});
    Reset = 1'b0; Start = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge Clk);
    check_outputs("reset");
    Reset = 1'b0;

    // Straight run to runoff.
    step(1, 0, 0, 0, 0, 0, 0, 0, "run.start");
    for (int i = 1; i < PLEN; i++) idle_step("run.inc");
    chk("run.last", int'(ProgCtr), 7);
    idle_step("run.off");
    chk("run.done", int'(Done), 1);
    idle_step("run.hold");
    chk("run.hold_pc", int'(ProgCtr), 7);

    // Taken branch via LUT[2]=5: 0,1,5,6.
    step(0, 0, 0, 0, 0, 1, 2, 5, "br.lutw");
    step(1, 0, 0, 0, 0, 0, 0, 0, "br.start");
    idle_step("br.pc1");
    step(0, 1, 1, 2, 0, 0, 0, 0, "br.take");
    chk("br.target", int'(ProgCtr), 5);
    idle_step("br.pc6");
    // Halt wins over a taken branch.
    step(0, 1, 1, 2, 1, 0, 0, 0, "halt");
    chk("halt.pc", int'(ProgCtr), 6);
    step(1, 0, 0, 0, 0, 0, 0, 0, "restart");
    chk("restart.pc", int'(ProgCtr), 0);
    // Not-taken branch and Taken-without-Branch both increment.
    step(0, 1, 0, 2, 0, 0, 0, 0, "nt");
    step(0, 0, 1, 2, 0, 0, 0, 0, "tk_only");
    chk("nt.pc", int'(ProgCtr), 2);

    // Same-cycle LUT write and read: branch takes the old value.
    step(0, 0, 0, 0, 0, 1, 1, 4, "haz.init");
    step(0, 1, 1, 1, 0, 1, 1, 6, "haz.same");
    chk("haz.old", int'(ProgCtr), 4);
    step(0, 1, 1, 1, 0, 0, 0, 0, "haz.new");
    chk("haz.newval", int'(ProgCtr), 6);

    // Out-of-range target ends the run with PC held.
    step(0, 0, 0, 0, 0, 1, 3, 1023, "oor.w");
    step(0, 1, 1, 3, 0, 0, 0, 0, "oor.br");
    chk("oor.pc", int'(ProgCtr), 7);
    chk("oor.done", int'(Done), 1);

    // Mid-run reset at PC 6 clears LUT too; branching via LUT[2] now goes to 0.
    step(1, 0, 0, 0, 0, 0, 0, 0, "rst.start");
    repeat (6) idle_step("rst.walk");
    async_reset("rst");
    step(1, 0, 0, 0, 0, 0, 0, 0, "rst.start2");
    idle_step("rst.pc1");
    step(0, 1, 1, 2, 0, 0, 0, 0, "rst.lutclr");
    chk("rst.lut0", int'(ProgCtr), 0);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 299) == 0) async_reset("rnd.rst");
      else step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 7),
                ($urandom_range(0, 15) == 0) ? 1023 : $urandom_range(0, 10),
                "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
